// File: rtl/corral_game_engine.sv
// corral_game_engine
//   Plays one cowboy-versus-horse game per start on a 2**X_BITS by
//   2**Y_BITS board. On each move, the cowboy steps in the direction
//   latched from `move`. The horse then steps in a pseudo-random
//   direction taken from a free-running 16-bit LFSR. The game is won
//   when the cowboy lands on the horse. It is lost when the turn
//   budget MAX_TURNS is used up.
//
// Ports
//   clock     in   rising-edge system clock
//   reset_n   in   asynchronous active-low reset
//   enter     in   move strobe (accepted only while ready=1)
//   move      in   direction code, valid with enter
//                  0=N 1=NE 2=E 3=SE 4=S 5=SW 6=W 7=NW; y grows downward
//   cowboy_x  out  cowboy column
//   cowboy_y  out  cowboy row
//   horse_x   out  horse column
//   horse_y   out  horse row
//   turn      out  completed turns in this game
//   ready     out  enter will be accepted on the next edge
//   gameover  out  game finished
//   lostwon   out  1 = won, 0 = lost; meaningful only while gameover=1
module corral_game_engine #(
  parameter int unsigned X_BITS    = 2,
  parameter int unsigned Y_BITS    = 2,
  parameter int unsigned TURN_BITS = 4,
  parameter int unsigned MAX_TURNS = 15,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enter,
  input  logic [2:0]           move,
  output logic [X_BITS-1:0]    cowboy_x,
  output logic [Y_BITS-1:0]    cowboy_y,
  output logic [X_BITS-1:0]    horse_x,
  output logic [Y_BITS-1:0]    horse_y,
  output logic [TURN_BITS-1:0] turn,
  output logic                 ready,
  output logic                 gameover,
  output logic                 lostwon
);

  localparam logic [X_BITS-1:0]    X_MAX    = '1;
  localparam logic [Y_BITS-1:0]    Y_MAX    = '1;
  localparam logic [TURN_BITS-1:0] TURN_SAT = '1;
  localparam logic [TURN_BITS-1:0] TURN_END = TURN_BITS'(MAX_TURNS);

  typedef enum logic [2:0] {
    ST_READY,
    ST_COWBOY,
    ST_HORSE,
    ST_CHECK,
    ST_OVER
  } state_e;

  state_e                state_q,   state_d;
  logic [X_BITS-1:0]     cow_x_q,   cow_x_d;
  logic [Y_BITS-1:0]     cow_y_q,   cow_y_d;
  logic [X_BITS-1:0]     hor_x_q,   hor_x_d;
  logic [Y_BITS-1:0]     hor_y_q,   hor_y_d;
  logic [TURN_BITS-1:0]  turn_q,    turn_d;
  logic [2:0]            move_q,    move_d;
  logic                  lostwon_q, lostwon_d;
  logic                  ready_q,   ready_d;
  logic                  over_q,    over_d;
  logic [15:0]           lfsr_q,    lfsr_d;

  // Candidate positions, clamped per axis before any register write.
  logic [X_BITS-1:0]     cow_nx;
  logic [Y_BITS-1:0]     cow_ny;
  logic [X_BITS-1:0]     hor_tx;
  logic [Y_BITS-1:0]     hor_ty;

  // One step along x. A step that would leave the board keeps the
  // current column (no wrap).
  function automatic logic [X_BITS-1:0] step_x(input logic [X_BITS-1:0] x,
                                               input logic [2:0]        dir);
    logic [X_BITS-1:0] r;
    r = x;
    case (dir)
      3'd1, 3'd2, 3'd3: if (x != X_MAX) r = x + X_BITS'(1);
      3'd5, 3'd6, 3'd7: if (x != '0)    r = x - X_BITS'(1);
      default:          r = x;
    endcase
    return r;
  endfunction

  // One step along y; north decreases y.
  function automatic logic [Y_BITS-1:0] step_y(input logic [Y_BITS-1:0] y,
                                               input logic [2:0]        dir);
    logic [Y_BITS-1:0] r;
    r = y;
    case (dir)
      3'd3, 3'd4, 3'd5: if (y != Y_MAX) r = y + Y_BITS'(1);
      3'd7, 3'd0, 3'd1: if (y != '0)    r = y - Y_BITS'(1);
      default:          r = y;
    endcase
    return r;
  endfunction

  always_comb begin
    cow_nx = step_x(cow_x_q, move_q);
    cow_ny = step_y(cow_y_q, move_q);
    hor_tx = step_x(hor_x_q, lfsr_q[2:0]);
    hor_ty = step_y(hor_y_q, lfsr_q[2:0]);
  end

  always_comb begin
    state_d   = state_q;
    cow_x_d   = cow_x_q;
    cow_y_d   = cow_y_q;
    hor_x_d   = hor_x_q;
    hor_y_d   = hor_y_q;
    turn_d    = turn_q;
    move_d    = move_q;
    lostwon_d = lostwon_q;
    // Taps 16,14,13,11. The LFSR runs in every state, so the horse's
    // direction depends on when the player moves.
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    case (state_q)
      ST_READY: begin
        if (enter) begin
          move_d  = move;
          state_d = ST_COWBOY;
        end
      end

      ST_COWBOY: begin
        cow_x_d = cow_nx;
        cow_y_d = cow_ny;
        if (cow_nx == hor_x_q && cow_ny == hor_y_q) begin
          lostwon_d = 1'b1;
          state_d   = ST_OVER;
        end else begin
          state_d   = ST_HORSE;
        end
      end

      ST_HORSE: begin
        // The horse never steps onto the cowboy. This keeps the
        // "shared cell means win" rule unambiguous.
        if (!(hor_tx == cow_x_q && hor_ty == cow_y_q)) begin
          hor_x_d = hor_tx;
          hor_y_d = hor_ty;
        end
        if (turn_q != TURN_SAT) begin
          turn_d = turn_q + TURN_BITS'(1);
        end
        state_d = ST_CHECK;
      end

      ST_CHECK: begin
        if (turn_q == TURN_END) begin
          lostwon_d = 1'b0;
          state_d   = ST_OVER;
        end else begin
          state_d   = ST_READY;
        end
      end

      ST_OVER: begin
        if (enter) begin
          cow_x_d   = '0;
          cow_y_d   = '0;
          hor_x_d   = X_MAX;
          hor_y_d   = Y_MAX;
          turn_d    = '0;
          lostwon_d = 1'b0;
          state_d   = ST_READY;
        end
      end

      default: state_d = ST_READY;
    endcase

    // Status flags are decoded from the next state, so they come out of
    // flops aligned with the state register.
    ready_d = (state_d == ST_READY) || (state_d == ST_OVER);
    over_d  = (state_d == ST_OVER);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_READY;
      cow_x_q   <= '0;
      cow_y_q   <= '0;
      hor_x_q   <= X_MAX;
      hor_y_q   <= Y_MAX;
      turn_q    <= '0;
      move_q    <= '0;
      lostwon_q <= 1'b0;
      ready_q   <= 1'b1;
      over_q    <= 1'b0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      state_q   <= state_d;
      cow_x_q   <= cow_x_d;
      cow_y_q   <= cow_y_d;
      hor_x_q   <= hor_x_d;
      hor_y_q   <= hor_y_d;
      turn_q    <= turn_d;
      move_q    <= move_d;
      lostwon_q <= lostwon_d;
      ready_q   <= ready_d;
      over_q    <= over_d;
      lfsr_q    <= lfsr_d;
    end
  end

  assign cowboy_x = cow_x_q;
  assign cowboy_y = cow_y_q;
  assign horse_x  = hor_x_q;
  assign horse_y  = hor_y_q;
  assign turn     = turn_q;
  assign ready    = ready_q;
  assign gameover = over_q;
  assign lostwon  = lostwon_q;

endmodule

// File: tb/tb_corral_game_engine.sv
module tb_corral_game_engine;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  logic       en [3];
  logic [2:0] mv [3];

  // u0: defaults, u1: 2x2 board, u2: MAX_TURNS=1
  logic [1:0] d0_cx, d0_cy, d0_hx, d0_hy;
  logic [0:0] d1_cx, d1_cy, d1_hx, d1_hy;
  logic [1:0] d2_cx, d2_cy, d2_hx, d2_hy;
  logic [3:0] d0_t, d1_t, d2_t;
  logic d0_r, d0_g, d0_l, d1_r, d1_g, d1_l, d2_r, d2_g, d2_l;

  corral_game_engine u0 (
    .clock(clock), .reset_n(reset_n), .enter(en[0]), .move(mv[0]),
    .cowboy_x(d0_cx), .cowboy_y(d0_cy), .horse_x(d0_hx), .horse_y(d0_hy),
    .turn(d0_t), .ready(d0_r), .gameover(d0_g), .lostwon(d0_l));

  corral_game_engine #(.X_BITS(1), .Y_BITS(1)) u1 (
    .clock(clock), .reset_n(reset_n), .enter(en[1]), .move(mv[1]),
    .cowboy_x(d1_cx), .cowboy_y(d1_cy), .horse_x(d1_hx), .horse_y(d1_hy),
    .turn(d1_t), .ready(d1_r), .gameover(d1_g), .lostwon(d1_l));

  corral_game_engine #(.MAX_TURNS(1)) u2 (
    .clock(clock), .reset_n(reset_n), .enter(en[2]), .move(mv[2]),
    .cowboy_x(d2_cx), .cowboy_y(d2_cy), .horse_x(d2_hx), .horse_y(d2_hy),
    .turn(d2_t), .ready(d2_r), .gameover(d2_g), .lostwon(d2_l));

  int a_cx[3], a_cy[3], a_hx[3], a_hy[3], a_t[3], a_r[3], a_g[3], a_l[3];
  always_comb begin
    a_cx[0] = int'(d0_cx); a_cy[0] = int'(d0_cy); a_hx[0] = int'(d0_hx); a_hy[0] = int'(d0_hy);
    a_cx[1] = int'(d1_cx); a_cy[1] = int'(d1_cy); a_hx[1] = int'(d1_hx); a_hy[1] = int'(d1_hy);
    a_cx[2] = int'(d2_cx); a_cy[2] = int'(d2_cy); a_hx[2] = int'(d2_hx); a_hy[2] = int'(d2_hy);
    a_t[0] = int'(d0_t); a_t[1] = int'(d1_t); a_t[2] = int'(d2_t);
    a_r[0] = int'(d0_r); a_r[1] = int'(d1_r); a_r[2] = int'(d2_r);
    a_g[0] = int'(d0_g); a_g[1] = int'(d1_g); a_g[2] = int'(d2_g);
    a_l[0] = int'(d0_l); a_l[1] = int'(d1_l); a_l[2] = int'(d2_l);
  end

  // ---------------- transaction-level model ----------------
  // When a move is accepted at edge E, the whole outcome is computed at
  // once. Each visible change is then scheduled for the edge where it
  // should appear.
  int XMAX[3] = '{3, 1, 3};
  int YMAX[3] = '{3, 1, 3};
  int MAXT[3] = '{15, 15, 1};
  localparam int TURN_SAT = 15;

  int m_cx[3], m_cy[3], m_hx[3], m_hy[3], m_t[3], m_g[3], m_l[3];
  int busy_until[3];
  int pc_t[3], pc_x[3], pc_y[3], pc_win[3];
  int ph_t[3], ph_x[3], ph_y[3], ph_turn[3];
  int po_t[3];
  int ne = 0;
  bit [15:0] m_lfsr;

  int n_vec  = 0;
  int n_fail = 0;

  function automatic bit [15:0] adv(input bit [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int dx_of(input int c);
    if (c >= 1 && c <= 3) return 1;
    if (c >= 5) return -1;
    return 0;
  endfunction

  function automatic int dy_of(input int c);
    if (c >= 3 && c <= 5) return 1;
    if (c == 7 || c <= 1) return -1;
    return 0;
  endfunction

  function automatic int clampstep(input int v, input int d, input int vmax);
    int n;
    n = v + d;
    if (n < 0 || n > vmax) return v;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cx[i] = 0; m_cy[i] = 0; m_hx[i] = XMAX[i]; m_hy[i] = YMAX[i];
      m_t[i] = 0; m_g[i] = 0; m_l[i] = 0;
      busy_until[i] = ne;
      pc_t[i] = -1; ph_t[i] = -1; po_t[i] = -1;
    end
    m_lfsr = 16'hACE1;
  endtask

  task automatic accept(input int i, input int c);
    int ncx, ncy, tx, ty, d;
    bit [15:0] l2;
    ncx = clampstep(m_cx[i], dx_of(c), XMAX[i]);
    ncy = clampstep(m_cy[i], dy_of(c), YMAX[i]);
    pc_t[i] = ne + 1; pc_x[i] = ncx; pc_y[i] = ncy;
    po_t[i] = -1;
    if (ncx == m_hx[i] && ncy == m_hy[i]) begin
      pc_win[i] = 1;
      busy_until[i] = ne + 1;
    end else begin
      pc_win[i] = 0;
      l2 = adv(adv(m_lfsr));      // LFSR value seen by the horse step at E+2
      d  = int'(l2[2:0]);
      tx = clampstep(m_hx[i], dx_of(d), XMAX[i]);
      ty = clampstep(m_hy[i], dy_of(d), YMAX[i]);
      if (tx == ncx && ty == ncy) begin tx = m_hx[i]; ty = m_hy[i]; end
      ph_t[i] = ne + 2; ph_x[i] = tx; ph_y[i] = ty;
      ph_turn[i] = (m_t[i] + 1 > TURN_SAT) ? TURN_SAT : m_t[i] + 1;
      if (ph_turn[i] == MAXT[i]) po_t[i] = ne + 3;
      busy_until[i] = ne + 3;
    end
  endtask

  always @(negedge reset_n) model_reset();

  always @(posedge clock) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      ne = ne + 1;
      for (int i = 0; i < 3; i++) begin
        if (pc_t[i] == ne) begin
          m_cx[i] = pc_x[i]; m_cy[i] = pc_y[i];
          if (pc_win[i] != 0) begin m_g[i] = 1; m_l[i] = 1; end
        end
        if (ph_t[i] == ne) begin
          m_hx[i] = ph_x[i]; m_hy[i] = ph_y[i]; m_t[i] = ph_turn[i];
        end
        if (po_t[i] == ne) begin m_g[i] = 1; m_l[i] = 0; end
        if (ne > busy_until[i] && en[i]) begin
          if (m_g[i] != 0) begin
            m_cx[i] = 0; m_cy[i] = 0; m_hx[i] = XMAX[i]; m_hy[i] = YMAX[i];
            m_t[i] = 0; m_g[i] = 0; m_l[i] = 0;
          end else begin
            accept(i, int'(mv[i]));
          end
        end
      end
      m_lfsr = adv(m_lfsr);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if ($time > 2) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d.cowboy_x", i), a_cx[i], m_cx[i]);
        chk($sformatf("u%0d.cowboy_y", i), a_cy[i], m_cy[i]);
        chk($sformatf("u%0d.horse_x", i), a_hx[i], m_hx[i]);
        chk($sformatf("u%0d.horse_y", i), a_hy[i], m_hy[i]);
        chk($sformatf("u%0d.turn", i), a_t[i], m_t[i]);
        chk($sformatf("u%0d.ready", i), a_r[i], (ne >= busy_until[i]) ? 1 : 0);
        chk($sformatf("u%0d.gameover", i), a_g[i], m_g[i]);
        chk($sformatf("u%0d.lostwon", i), a_l[i], m_l[i]);
      end
    end
  end

  // ---------------- directed stimulus with hand-computed pins ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin en[i] = 1'b0; mv[i] = 3'd0; end
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Idle after reset: nothing moves.
    repeat (20) @(negedge clock);
    chk("idle.cowboy_x", a_cx[0], 0);
    chk("idle.horse_x",  a_hx[0], 3);
    chk("idle.horse_y",  a_hy[0], 3);
    chk("idle.turn",     a_t[0], 0);
    chk("idle.ready",    a_r[0], 1);
    chk("idle.u1.horse_x", a_hx[1], 1);

    // Fresh reset, then all three boards accept on the first edge,
    // with the LFSR at its seed. Horse direction = lfsr[2:0] at E+2
    // = 16'hB387[2:0] = 7 (NW).
    @(posedge clock); #1 reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    en[0] = 1'b1; mv[0] = 3'd0;
    en[1] = 1'b1; mv[1] = 3'd3;
    en[2] = 1'b1; mv[2] = 3'd2;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) en[i] = 1'b0;
    @(negedge clock);                      // after E
    chk("E.u0.ready", a_r[0], 0);
    @(negedge clock);                      // after E+1
    chk("E1.u0.cowboy_y", a_cy[0], 0);
    chk("E1.u1.cowboy_x", a_cx[1], 1);
    chk("E1.u1.cowboy_y", a_cy[1], 1);
    chk("E1.u1.gameover", a_g[1], 1);
    chk("E1.u1.lostwon",  a_l[1], 1);
    chk("E1.u1.ready",    a_r[1], 1);
    chk("E1.u1.turn",     a_t[1], 0);
    chk("E1.u1.horse_x",  a_hx[1], 1);
    chk("E1.u2.cowboy_x", a_cx[2], 1);
    chk("E1.u0.horse_x",  a_hx[0], 3);
    @(negedge clock);                      // after E+2
    chk("E2.u0.horse_x", a_hx[0], 2);
    chk("E2.u0.horse_y", a_hy[0], 2);
    chk("E2.u0.turn",    a_t[0], 1);
    chk("E2.u0.ready",   a_r[0], 0);
    chk("E2.u2.turn",    a_t[2], 1);
    @(negedge clock);                      // after E+3
    chk("E3.u0.ready",    a_r[0], 1);
    chk("E3.u0.gameover", a_g[0], 0);
    chk("E3.u2.gameover", a_g[2], 1);
    chk("E3.u2.lostwon",  a_l[2], 0);
    chk("E3.u2.turn",     a_t[2], 1);

    // Restart the lost game on u2.
    en[2] = 1'b1; mv[2] = 3'd5;
    @(posedge clock); #1 en[2] = 1'b0;
    @(negedge clock);
    chk("restart.gameover", a_g[2], 0);
    chk("restart.cowboy_x", a_cx[2], 0);
    chk("restart.horse_x",  a_hx[2], 3);
    chk("restart.horse_y",  a_hy[2], 3);
    chk("restart.turn",     a_t[2], 0);

    // enter held for 6 edges: only 2 moves are taken.
    @(posedge clock); #1 reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    en[0] = 1'b1; mv[0] = 3'd4;
    repeat (6) @(posedge clock);
    #1 en[0] = 1'b0;
    repeat (4) @(negedge clock);
    chk("hold.turn",     a_t[0], 2);
    chk("hold.cowboy_x", a_cx[0], 0);
    chk("hold.cowboy_y", a_cy[0], 2);

    // Reset while the horse step is pending.
    @(negedge clock);
    if (a_g[0] != 0) begin
      en[0] = 1'b1;
      @(posedge clock); #1 en[0] = 1'b0;
    end
    repeat (2) @(negedge clock);
    en[0] = 1'b1; mv[0] = 3'd2;
    @(posedge clock); #1 en[0] = 1'b0;     // E
    @(posedge clock); #2;                  // E+1: now in HORSE
    reset_n = 1'b0;
    #1;
    chk("arst.cowboy_x", a_cx[0], 0);
    chk("arst.cowboy_y", a_cy[0], 0);
    chk("arst.horse_x",  a_hx[0], 3);
    chk("arst.turn",     a_t[0], 0);
    chk("arst.ready",    a_r[0], 1);
    chk("arst.gameover", a_g[0], 0);
    @(posedge clock); #1 reset_n = 1'b1;
    en[0] = 1'b1; mv[0] = 3'd0;
    @(posedge clock); #1 en[0] = 1'b0;
    @(negedge clock);
    chk("post.horse_x", a_hx[0], 3);
    repeat (2) @(negedge clock);
    chk("post.horse_x2", a_hx[0], 2);
    chk("post.horse_y2", a_hy[0], 2);
    chk("post.turn",     a_t[0], 1);

    repeat (4) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
